// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and widths for the NoC-AXI4 bridge response path.
package noc_axi4_bridge_pkg;

    localparam int unsigned MSG_HEADER_WIDTH = 64;
    localparam int unsigned AXI4_DATA_WIDTH  = 64;
    localparam int unsigned BURST_CNT_WIDTH  = 4;

    typedef enum logic {SRC_RD = 1'b0, SRC_WR = 1'b1} resp_src_e;

    typedef logic [BURST_CNT_WIDTH-1:0] burst_cnt_t;

endpackage

// File: rtl/noc_axi4_bridge_rr_pick.sv
// Weighted round-robin grant decision between the RD and WR response sources.
module noc_axi4_bridge_rr_pick
    import noc_axi4_bridge_pkg::*;
#(
    parameter int unsigned BURST_MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_rd,
    input  logic req_wr,
    input  logic load_en,
    output logic gnt_rd,
    output logic gnt_wr
);

    localparam burst_cnt_t BurstMax = burst_cnt_t'(BURST_MAX);

    resp_src_e  last_src_q, last_src_d;
    resp_src_e  pick;
    resp_src_e  other_src;
    burst_cnt_t burst_cnt_q, burst_cnt_d;
    logic       any_req;

    assign any_req   = req_rd | req_wr;
    assign other_src = (last_src_q == SRC_RD) ? SRC_WR : SRC_RD;

    always_comb begin
        pick        = SRC_RD;
        last_src_d  = last_src_q;
        burst_cnt_d = burst_cnt_q;

        if (req_rd && req_wr) begin
            // On a tie, stay with the current source until its burst budget is spent.
            if (burst_cnt_q < BurstMax) begin
                pick = last_src_q;
            end else begin
                pick = other_src;
            end
        end else if (req_wr) begin
            pick = SRC_WR;
        end

        gnt_rd = load_en & any_req & (pick == SRC_RD);
        gnt_wr = load_en & any_req & (pick == SRC_WR);

        if (gnt_rd || gnt_wr) begin
            if (pick == last_src_q) begin
                if (burst_cnt_q < BurstMax) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                last_src_d  = pick;
                burst_cnt_d = burst_cnt_t'(1);
            end
        end
    end

    // Reset state makes the first tie go to RD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_src_q  <= SRC_WR;
            burst_cnt_q <= BurstMax;
        end else begin
            last_src_q  <= last_src_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/noc_axi4_bridge_resp_arb.sv
// Merges read and write responses into a one-entry registered slot feeding the serializer.
module noc_axi4_bridge_resp_arb
    import noc_axi4_bridge_pkg::*;
#(
    parameter int unsigned BURST_MAX = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MSG_HEADER_WIDTH-1:0] rd_header_in,
    input  logic [AXI4_DATA_WIDTH-1:0]  rd_data_in,
    input  logic                        rd_val,
    output logic                        rd_rdy,
    input  logic [MSG_HEADER_WIDTH-1:0] wr_header_in,
    input  logic                        wr_val,
    output logic                        wr_rdy,
    output logic [MSG_HEADER_WIDTH-1:0] ser_header_out,
    output logic [AXI4_DATA_WIDTH-1:0]  ser_data_out,
    output logic                        ser_val,
    input  logic                        ser_rdy,
    output logic                        ser_src
);

    logic                        load_en;
    logic                        gnt_rd;
    logic                        gnt_wr;
    logic [MSG_HEADER_WIDTH-1:0] header_q;
    logic [AXI4_DATA_WIDTH-1:0]  data_q;
    resp_src_e                   src_q;
    logic                        val_q;

    // Gating with rst_n keeps both readies low while reset is held.
    assign load_en = rst_n & (~val_q | ser_rdy);

    noc_axi4_bridge_rr_pick #(
        .BURST_MAX (BURST_MAX)
    ) u_rr_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_rd  (rd_val),
        .req_wr  (wr_val),
        .load_en (load_en),
        .gnt_rd  (gnt_rd),
        .gnt_wr  (gnt_wr)
    );

    assign rd_rdy = gnt_rd;
    assign wr_rdy = gnt_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            header_q <= '0;
            data_q   <= '0;
            src_q    <= SRC_RD;
            val_q    <= 1'b0;
        end else if (load_en) begin
            if (gnt_rd) begin
                header_q <= rd_header_in;
                data_q   <= rd_data_in;
                src_q    <= SRC_RD;
                val_q    <= 1'b1;
            end else if (gnt_wr) begin
                header_q <= wr_header_in;
                data_q   <= '0;
                src_q    <= SRC_WR;
                val_q    <= 1'b1;
            end else begin
                val_q    <= 1'b0;
            end
        end
    end

    assign ser_header_out = header_q;
    assign ser_data_out   = data_q;
    assign ser_val        = val_q;
    assign ser_src        = src_q;

endmodule

// File: tb/tb_noc_axi4_bridge_resp_arb.sv
// Bench for the response arbiter: two instances (BURST_MAX 1 and 3) share one stimulus stream.
module tb_noc_axi4_bridge_resp_arb;
    import noc_axi4_bridge_pkg::*;

    localparam int HW = MSG_HEADER_WIDTH;
    localparam int DW = AXI4_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] rd_hdr, wr_hdr;
    logic [DW-1:0] rd_data;
    logic          rd_val, wr_val, ser_rdy;

    logic          rd_rdy1, wr_rdy1, ser_val1, ser_src1;
    logic [HW-1:0] ser_hdr1;
    logic [DW-1:0] ser_data1;
    logic          rd_rdy3, wr_rdy3, ser_val3, ser_src3;
    logic [HW-1:0] ser_hdr3;
    logic [DW-1:0] ser_data3;

    always #5 clk = ~clk;

    noc_axi4_bridge_resp_arb #(.BURST_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rd_header_in(rd_hdr), .rd_data_in(rd_data), .rd_val(rd_val), .rd_rdy(rd_rdy1),
        .wr_header_in(wr_hdr), .wr_val(wr_val), .wr_rdy(wr_rdy1),
        .ser_header_out(ser_hdr1), .ser_data_out(ser_data1), .ser_val(ser_val1),
        .ser_rdy(ser_rdy), .ser_src(ser_src1)
    );

    noc_axi4_bridge_resp_arb #(.BURST_MAX(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .rd_header_in(rd_hdr), .rd_data_in(rd_data), .rd_val(rd_val), .rd_rdy(rd_rdy3),
        .wr_header_in(wr_hdr), .wr_val(wr_val), .wr_rdy(wr_rdy3),
        .ser_header_out(ser_hdr3), .ser_data_out(ser_data3), .ser_val(ser_val3),
        .ser_rdy(ser_rdy), .ser_src(ser_src3)
    );

    logic          o_rd[2], o_wr[2], o_val[2], o_src[2];
    logic [HW-1:0] o_hdr[2];
    logic [DW-1:0] o_data[2];
    assign o_rd[0] = rd_rdy1;     assign o_rd[1] = rd_rdy3;
    assign o_wr[0] = wr_rdy1;     assign o_wr[1] = wr_rdy3;
    assign o_val[0] = ser_val1;   assign o_val[1] = ser_val3;
    assign o_src[0] = ser_src1;   assign o_src[1] = ser_src3;
    assign o_hdr[0] = ser_hdr1;   assign o_hdr[1] = ser_hdr3;
    assign o_data[0] = ser_data1; assign o_data[1] = ser_data3;

    int checks = 0;
    int failures = 0;

    // Reference model: one slot plus {last source, burst count} per instance.
    int            bmax[2] = '{1, 3};
    logic          m_val[2], m_src[2], m_last[2];
    logic [HW-1:0] m_hdr[2];
    logic [DW-1:0] m_data[2];
    int            m_cnt[2];
    logic          g_rd[2], g_wr[2];
    int            wait_c[2][2];

    typedef struct packed {
        logic          src;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
    } item_t;
    item_t q0[$], q1[$];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_val[i]  = 1'b0;
        m_src[i]  = 1'b0;
        m_hdr[i]  = '0;
        m_data[i] = '0;
        m_last[i] = 1'b1;
        m_cnt[i]  = bmax[i];
    endtask

    task automatic scoreboard(input int i);
        item_t it, got;
        if (!rst_n) begin
            if (i == 0) q0.delete(); else q1.delete();
            return;
        end
        if (o_val[i] && ser_rdy) begin
            got = '{src: o_src[i], hdr: o_hdr[i], data: o_data[i]};
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("sb_unexpected_output[b%0d]", bmax[i]), 1, 0);
            end else begin
                it = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("sb_order[b%0d]", bmax[i]), got, it);
            end
        end
        if (rd_val && o_rd[i]) begin
            it = '{src: 1'b0, hdr: rd_hdr, data: rd_data};
            if (i == 0) q0.push_back(it); else q1.push_back(it);
        end
        if (wr_val && o_wr[i]) begin
            it = '{src: 1'b1, hdr: wr_hdr, data: '0};
            if (i == 0) q0.push_back(it); else q1.push_back(it);
        end
    endtask

    task automatic starvation(input int i);
        logic xv, xg, og;
        for (int x = 0; x < 2; x++) begin
            if (!rst_n) begin
                wait_c[i][x] = 0;
            end else begin
                xv = (x == 1) ? wr_val : rd_val;
                xg = (x == 1) ? o_wr[i] : o_rd[i];
                og = (x == 1) ? o_rd[i] : o_wr[i];
                if (xg || !xv) begin
                    wait_c[i][x] = 0;
                end else if (og) begin
                    wait_c[i][x]++;
                    check($sformatf("starve_src%0d[b%0d]", x, bmax[i]),
                          (wait_c[i][x] <= bmax[i]), 1);
                end
            end
        end
    endtask

    // One cycle: inputs already driven after a negedge; compare, advance model, cross posedge.
    task automatic step();
        logic load, have, g;
        #1;
        for (int i = 0; i < 2; i++) begin
            load = rst_n && (!m_val[i] || ser_rdy);
            have = 1'b0;
            g    = 1'b0;
            if (load) begin
                if (rd_val && wr_val) begin
                    have = 1'b1;
                    g    = (m_cnt[i] < bmax[i]) ? m_last[i] : !m_last[i];
                end else if (rd_val) begin
                    have = 1'b1;
                end else if (wr_val) begin
                    have = 1'b1;
                    g    = 1'b1;
                end
            end
            check($sformatf("rd_rdy[b%0d]", bmax[i]), o_rd[i], have && !g);
            check($sformatf("wr_rdy[b%0d]", bmax[i]), o_wr[i], have && g);
            check($sformatf("ser_val[b%0d]", bmax[i]), o_val[i], m_val[i]);
            if (m_val[i]) begin
                check($sformatf("ser_header[b%0d]", bmax[i]), o_hdr[i], m_hdr[i]);
                check($sformatf("ser_data[b%0d]", bmax[i]), o_data[i], m_data[i]);
                check($sformatf("ser_src[b%0d]", bmax[i]), o_src[i], m_src[i]);
            end
            g_rd[i] = o_rd[i];
            g_wr[i] = o_wr[i];
            scoreboard(i);
            starvation(i);
            if (!rst_n) begin
                model_reset(i);
            end else if (load) begin
                if (have) begin
                    m_val[i]  = 1'b1;
                    m_src[i]  = g;
                    m_hdr[i]  = g ? wr_hdr : rd_hdr;
                    m_data[i] = g ? '0 : rd_data;
                    if (g == m_last[i]) begin
                        if (m_cnt[i] < bmax[i]) m_cnt[i]++;
                    end else begin
                        m_last[i] = g;
                        m_cnt[i]  = 1;
                    end
                end else begin
                    m_val[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [8:0] pat1, pat3;

    initial begin
        rst_n = 1'b0; rd_val = 1'b0; wr_val = 1'b0; ser_rdy = 1'b0;
        rd_hdr = '0; wr_hdr = '0; rd_data = '0;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            wait_c[i][0] = 0;
            wait_c[i][1] = 0;
        end
        @(negedge clk);

        // Reset held with both sources requesting: no ready may rise.
        rd_val = 1'b1; wr_val = 1'b1; ser_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_rdy", {g_rd[0], g_wr[0], g_rd[1], g_wr[1]}, 4'b0000);
        end
        check("reset_ser_val", {ser_val1, ser_val3}, 2'b00);
        check("reset_ser_src", {ser_src1, ser_src3}, 2'b00);
        check("reset_ser_header", {ser_hdr1, ser_hdr3}, 0);
        check("reset_ser_data", {ser_data1, ser_data3}, 0);

        // Single RD response: ready same cycle, slot full next cycle.
        rst_n = 1'b1; wr_val = 1'b0;
        rd_hdr = 64'h1111_0000_0000_00A1; rd_data = 64'hDDDD_0000_0000_00D1;
        step();
        check("t1_rd_rdy", {g_rd[0], g_rd[1]}, 2'b11);
        rd_val = 1'b0;
        check("t1_ser_val", {ser_val1, ser_val3}, 2'b11);
        check("t1_ser_header1", ser_hdr1, 64'h1111_0000_0000_00A1);
        check("t1_ser_header3", ser_hdr3, 64'h1111_0000_0000_00A1);
        check("t1_ser_data1", ser_data1, 64'hDDDD_0000_0000_00D1);
        check("t1_ser_data3", ser_data3, 64'hDDDD_0000_0000_00D1);
        check("t1_ser_src", {ser_src1, ser_src3}, 2'b00);
        step();

        // Fresh reset, then continuous tie with the sink always ready.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; rd_val = 1'b1; wr_val = 1'b1; ser_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rd_hdr = 64'hA000 + 64'(k); wr_hdr = 64'hB000 + 64'(k); rd_data = 64'hD000 + 64'(k);
            step();
            pat1[k] = g_wr[0];
            pat3[k] = g_wr[1];
            if (ser_src1) check("t2_wr_data_zero1", ser_data1, 0);
            if (ser_src3) check("t2_wr_data_zero3", ser_data3, 0);
        end
        check("t2_pattern_b1", pat1, 9'b010101010);
        check("t2_pattern_b3", pat3, 9'b000111000);

        // Sink stalls with a full slot: no ready, slot frozen on the last RD entry.
        ser_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd_hdr = 64'hA100 + 64'(k); wr_hdr = 64'hB100 + 64'(k);
            step();
            check("t3_stall_rdy", {g_rd[0], g_wr[0], g_rd[1], g_wr[1]}, 4'b0000);
            check("t3_stall_header1", ser_hdr1, 64'hA008);
            check("t3_stall_header3", ser_hdr3, 64'hA008);
        end
        ser_rdy = 1'b1; rd_hdr = 64'hA200; wr_hdr = 64'hB200;
        step();
        check("t3_refill_val", {ser_val1, ser_val3}, 2'b11);
        check("t3_refill_header1", ser_hdr1, 64'hB200);
        check("t3_refill_header3", ser_hdr3, 64'hB200);

        // Reset pulse while the slot is full.
        rst_n = 1'b0;
        step();
        check("t4_reset_drop_val", {ser_val1, ser_val3}, 2'b00);
        rst_n = 1'b1;
        step();
        check("t4_tie_after_reset", {g_rd[0], g_rd[1]}, 2'b11);

        // Random traffic against the model and scoreboard.
        for (int k = 0; k < 10000; k++) begin
            rst_n   = ($urandom_range(0, 499) != 0);
            rd_val  = ($urandom_range(0, 2) != 0);
            wr_val  = ($urandom_range(0, 2) != 0);
            ser_rdy = ($urandom_range(0, 3) != 0);
            rd_hdr  = {$urandom, $urandom};
            wr_hdr  = {$urandom, $urandom};
            rd_data = {$urandom, $urandom};
            step();
        end

        // Drain: every accepted response must have left exactly once.
        rst_n = 1'b1; rd_val = 1'b0; wr_val = 1'b0; ser_rdy = 1'b1;
        step();
        step();
        check("drain_queue1", q0.size(), 0);
        check("drain_queue3", q1.size(), 0);
        check("drain_ser_val", {ser_val1, ser_val3}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_axi4_bridge_resp_arb.md
# noc_axi4_bridge_resp_arb

Arbitrates the read-response and write-response streams of the NoC–AXI4 bridge onto the single response serializer input. Weighted round-robin between the two sources drives a one-entry registered output slot with full-throughput valid/ready handshakes. Sits between the AXI4 R/B response handlers and the response serializer.

## Interface
- BURST_MAX, 1: max consecutive grants to one source while the other is waiting; range 1..15.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- rd_header_in  in  `MSG_HEADER_WIDTH  request header of a read response.
- rd_data_in  in  `AXI4_DATA_WIDTH  read data.
- rd_val  in  1  read response valid.
- rd_rdy  out  1  read response accepted when rd_val & rd_rdy.
- wr_header_in  in  `MSG_HEADER_WIDTH  request header of a write response.
- wr_val  in  1  write response valid.
- wr_rdy  out  1  write response accepted when wr_val & wr_rdy.
- ser_header_out  out  `MSG_HEADER_WIDTH  header to serializer; registered.
- ser_data_out  out  `AXI4_DATA_WIDTH  data to serializer; registered; all-zero for write entries.
- ser_val  out  1  slot full; registered.
- ser_rdy  in  1  serializer ready.
- ser_src  out  1  source of slot contents (0 = RD, 1 = WR); registered.

## Operation
- Single output slot {header, data, src, val}.
- load_en = ~ser_val | ser_rdy. The slot drains and refills in the same cycle.
- Arbitration, evaluated only when load_en = 1:
  - Only one source valid: that source is granted.
  - Both valid: grant last_src if burst_cnt < BURST_MAX, else the other source.
  - Neither valid: no grant. If ser_rdy drained the slot, ser_val falls to 0.
- rd_rdy = load_en & grant_rd; wr_rdy = load_en & grant_wr.
  - Ready is combinational from val/ser_rdy.
  - Upstream val must not depend on rdy.
  - At most one rdy is high in any cycle.
- On grant, the slot loads the granted header and data (zero for WR), src = granted source, ser_val = 1.
  - If granted == last_src: burst_cnt = min(burst_cnt+1, BURST_MAX).
  - Otherwise: last_src = granted, burst_cnt = 1.
- No grant: last_src and burst_cnt hold.
- While ser_val & ~ser_rdy, all slot outputs are stable. No rdy is asserted.
- Header contents are passed through unmodified. No type decoding.

## Timing
- Reset values:
  - ser_val = 0, ser_src = 0, ser_header_out = 0, ser_data_out = 0.
  - last_src = WR, burst_cnt = BURST_MAX, so the first tie grants RD.
- rd_rdy and wr_rdy are 0 during reset.
- Latency: accepted in cycle N, ser_val high in cycle N+1.
- Throughput: one message per cycle while ser_rdy stays 1.
- Simultaneous ser_rdy drain and new grant: the new entry replaces the old one with no bubble. ser_val stays 1.
- Reset mid-operation: the slot content is discarded (ser_val = 0 next cycle). Upstream handshakes already completed are not replayed.
- Arbitration state changes only on a grant. Idle cycles do not reset fairness.

## Structure
- Shared package noc_axi4_bridge_pkg:
  - typedef enum logic {SRC_RD = 1'b0, SRC_WR = 1'b1} resp_src_e.
  - Burst counter width constant (4 bits).
- Sub-module noc_axi4_bridge_rr_pick holds the grant decision, last_src, and burst_cnt. Interface: two req bits, load_en, BURST_MAX; outputs two grant bits.
- The top level holds the output slot and the ready logic.

## Test plan
- Reset, then rd_val only with header H1 and data D1, ser_rdy = 1 → rd_rdy = 1 in cycle 0. Cycle 1: ser_val = 1, ser_header_out = H1, ser_data_out = D1, ser_src = 0.
- BURST_MAX = 1, both valid continuously, ser_rdy = 1 → grants alternate RD, WR, RD, WR…. ser_data_out = 0 on WR entries.
- BURST_MAX = 3, both valid continuously → grant pattern RD×3, WR×3, RD×3.
- ser_rdy = 0 for 5 cycles with a full slot, both sources valid → rd_rdy = wr_rdy = 0 and slot outputs stable. When ser_rdy rises, the same-cycle refill keeps ser_val = 1 with the new header.
- rst_n pulsed low for 1 cycle while ser_val = 1 → ser_val = 0 next cycle. The next tie grants RD.
- Random val/ser_rdy for 10k cycles against a scoreboard:
  - Output order equals grant order.
  - No loss or duplication.
  - No source starves more than BURST_MAX grants while valid.
